hyperbus_cs_sequencer: RTL and testbench
========================================

# hyperbus_cs_sequencer

Chip-select and clock-enable sequencer for the HyperBus PHY, running in the 90°-shifted TX clock domain. It takes one transaction descriptor at a time from the controller (target chip, number of CK cycles, minimum CS-high recovery time) and drives the registered chip selects and the output-clock enable with enforced setup, hold and recovery guards. During the command/address phase it samples RWDS at a fixed CK index and reports the value so the controller can choose single or doubled initial latency.

## Interface

Parameters:
- NumChips, 2, number of chip selects.
- CssCycles, 1, CS-low cycles before the first CK (t_CSS); must be ≥1.
- CshCycles, 1, CS-low cycles after the last CK (t_CSH); must be ≥1.
- RwdsSampleIdx, 2, 0-based ACTIVE-cycle index at which RWDS is sampled.
- ChipIdxW, $clog2(NumChips) (min 1), width of the chip index.

Ports:
- tx_clk_90  in  1  90°-shifted TX clock; all logic is on its rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  1  descriptor valid.
- req_ready_o  out  1  descriptor accepted when high together with valid; high only in IDLE.
- req_chip_i  in  ChipIdxW  target chip index.
- req_ck_cycles_i  in  16  number of CK cycles to enable (0 allowed).
- req_rwr_cycles_i  in  4  minimum CS-high cycles after the transaction.
- abort_i  in  1  terminate the current transaction.
- hyper_rwds_i  in  1  RWDS pad input, used for sampling.
- hyper_cs_no  out  NumChips  active-low chip selects, registered.
- ck_ena_o  out  1  output-clock enable, registered.
- rwds_sample_o  out  1  last sampled RWDS value.
- rwds_sample_valid_o  out  1  one-cycle pulse when rwds_sample_o is updated.
- done_o  out  1  one-cycle pulse at the end of a transaction, including aborted ones.
- busy_o  out  1  high in every state except IDLE.

## Operation

- The FSM has five states: IDLE, SETUP, ACTIVE, HOLD, RECOVER.
- IDLE: when req_valid_i && req_ready_o, latch chip, cycles and rwr, then go to SETUP.
- SETUP: CS low, CK disabled, for CssCycles cycles. Then go to ACTIVE if cycles > 0, otherwise go to HOLD.
- ACTIVE: CS low, ck_ena_o high, for exactly req_ck_cycles_i cycles. A 16-bit down-counter is loaded on entry.
  - At ACTIVE cycle index RwdsSampleIdx, register hyper_rwds_i into rwds_sample_o.
  - If cycles ≤ RwdsSampleIdx, no sample is taken and rwds_sample_o keeps its old value.
- HOLD: CS low, CK disabled, for CshCycles cycles, then go to RECOVER.
- RECOVER: all CS high, CK disabled, for max(rwr,1) cycles, then go to IDLE.
- Chip index ≥ NumChips: no CS bit is asserted, but the full timing sequence still runs.
- Only the latched chip's CS bit is ever low; it is never low outside SETUP, ACTIVE and HOLD.
- abort_i in SETUP, ACTIVE or HOLD: the next state is RECOVER, with CS high and CK disabled on the next edge, and done_o pulses.
  - The latched rwr still applies.
  - abort_i in IDLE or RECOVER is ignored.
  - Abort takes priority over the normal transitions and over sampling in the same cycle.
- Descriptor inputs are ignored outside IDLE.

## Timing

- Reset values: hyper_cs_no all ones, ck_ena_o 0, rwds_sample_o 0, rwds_sample_valid_o 0, done_o 0, busy_o 0, req_ready_o 1, state IDLE, counters 0.
- Handshake at edge t: hyper_cs_no[chip] is low from t+1.
- ck_ena_o is high during cycles t+1+Css … t+Css+N.
- CS returns high at t+1+Css+N+Csh.
- done_o pulses in the first RECOVER cycle, i.e. the same cycle CS goes high.
- req_ready_o returns high at t+1+Css+N+Csh+max(rwr,1), so the minimum back-to-back request spacing is Css+N+Csh+max(rwr,1)+1 cycles.
- rwds_sample_valid_o pulses in the cycle after the sampling edge, i.e. at ACTIVE cycle index RwdsSampleIdx+1, or the first HOLD cycle if that index falls past the end of ACTIVE.
- Abort asserted in cycle k: CS high and ck_ena_o low from k+1; done_o high in k+1 only.
- Reset asserted mid-transaction: all outputs return to their reset values immediately (asynchronous), with no done_o.
- Counters never wrap. N=0xFFFF runs exactly 65535 ACTIVE cycles.

## Test plan

- Chip 1, N=6, rwr=2, defaults, RWDS=1 throughout. Required:
  - hyper_cs_no=2'b01 for 1+6+1 cycles; ck_ena_o high for exactly 6 cycles, starting one cycle after CS falls.
  - rwds_sample_o=1 with a valid pulse at ACTIVE index 3.
  - done_o pulse when CS rises; ready returns 2 cycles later.
- N=0, chip 0. Required: CS low for exactly 2 cycles, ck_ena_o never high, no sample pulse, one done_o pulse.
- N=2 with RwdsSampleIdx=2. Required: no rwds_sample_valid_o pulse, and rwds_sample_o keeps its prior value.
- abort_i in the 3rd ACTIVE cycle of N=10. Required: on the next cycle CS goes high, ck_ena_o goes low and done_o pulses; the remaining ACTIVE cycles are skipped; ready returns after rwr cycles.
- Back-to-back requests with req_valid_i held high and rwr=0. Required:
  - The second accept occurs only when req_ready_o rises.
  - CS stays high for at least 1 cycle between transactions.
  - Changing the descriptor inputs mid-transaction has no effect.
- rst_ni pulsed low during ACTIVE. Required: hyper_cs_no goes all ones and ck_ena_o goes 0 asynchronously, with no done_o; a new request is accepted normally after release.

Source files
------------

// File: rtl/hyperbus_cs_sequencer.sv
// HyperBus chip-select / clock-enable sequencer in the tx_clk_90 domain.
// Walks SETUP -> ACTIVE -> HOLD -> RECOVER per descriptor and samples RWDS once.
module hyperbus_cs_sequencer #(
  parameter int unsigned NumChips      = 2,
  parameter int unsigned CssCycles     = 1,
  parameter int unsigned CshCycles     = 1,
  parameter int unsigned RwdsSampleIdx = 2,
  parameter int unsigned ChipIdxW      = (NumChips > 1) ? $clog2(NumChips) : 1
) (
  input  logic                tx_clk_90,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [ChipIdxW-1:0] req_chip_i,
  input  logic [15:0]         req_ck_cycles_i,
  input  logic [3:0]          req_rwr_cycles_i,
  input  logic                abort_i,
  input  logic                hyper_rwds_i,
  output logic [NumChips-1:0] hyper_cs_no,
  output logic                ck_ena_o,
  output logic                rwds_sample_o,
  output logic                rwds_sample_valid_o,
  output logic                done_o,
  output logic                busy_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACTIVE,
    ST_HOLD,
    ST_RECOVER
  } state_e;

  localparam logic [15:0] CssLoad = 16'(CssCycles - 1);
  localparam logic [15:0] CshLoad = 16'(CshCycles - 1);

  state_e              state_reg, state_next;
  logic [15:0]         cnt_reg, cnt_next;
  logic [15:0]         cycles_reg, cycles_next;
  logic [ChipIdxW-1:0] chip_reg, chip_next;
  logic [3:0]          rwr_reg, rwr_next;

  logic [NumChips-1:0] cs_reg, cs_next;
  logic                ck_ena_reg, ck_ena_next;
  logic                sample_reg, sample_next;
  logic                sample_valid_reg;
  logic                done_reg, done_next;

  logic [15:0]         rwr_load;
  logic [16:0]         active_idx;
  logic                sample_fire;
  logic                abort_hit;
  logic                cs_on_next;

  // RECOVER lasts at least one cycle even when rwr is 0.
  assign rwr_load   = (rwr_reg == 4'd0) ? 16'd0 : ({12'd0, rwr_reg} - 16'd1);
  assign active_idx = {1'b0, cycles_reg} - {1'b0, cnt_reg} - 17'd1;
  assign abort_hit  = abort_i && ((state_reg == ST_SETUP) || (state_reg == ST_ACTIVE) ||
                                  (state_reg == ST_HOLD));
  assign sample_fire = (state_reg == ST_ACTIVE) && !abort_i &&
                       (active_idx == 17'(RwdsSampleIdx));

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    cycles_next = cycles_reg;
    chip_next   = chip_reg;
    rwr_next    = rwr_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (req_valid_i) begin
          chip_next   = req_chip_i;
          cycles_next = req_ck_cycles_i;
          rwr_next    = req_rwr_cycles_i;
          cnt_next    = CssLoad;
          state_next  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_reg != 16'd0) begin
          cnt_next = cnt_reg - 16'd1;
        end else if (cycles_reg != 16'd0) begin
          cnt_next   = cycles_reg - 16'd1;
          state_next = ST_ACTIVE;
        end else begin
          cnt_next   = CshLoad;
          state_next = ST_HOLD;
        end
      end
      ST_ACTIVE: begin
        if (cnt_reg != 16'd0) begin
          cnt_next = cnt_reg - 16'd1;
        end else begin
          cnt_next   = CshLoad;
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_reg != 16'd0) begin
          cnt_next = cnt_reg - 16'd1;
        end else begin
          cnt_next   = rwr_load;
          state_next = ST_RECOVER;
        end
      end
      ST_RECOVER: begin
        if (cnt_reg != 16'd0) begin
          cnt_next = cnt_reg - 16'd1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = 16'd0;
      end
    endcase
    // Abort overrides whatever the counters decided this cycle.
    if (abort_hit) begin
      cnt_next   = rwr_load;
      state_next = ST_RECOVER;
    end
  end

  assign cs_on_next  = (state_next == ST_SETUP) || (state_next == ST_ACTIVE) ||
                       (state_next == ST_HOLD);
  assign ck_ena_next = (state_next == ST_ACTIVE);
  assign done_next   = (state_next == ST_RECOVER) && (state_reg != ST_RECOVER);
  assign sample_next = sample_fire ? hyper_rwds_i : sample_reg;

  // Out-of-range chip indices match no bit, so every CS stays high.
  for (genvar gi = 0; gi < NumChips; gi++) begin : g_cs
    assign cs_next[gi] = !(cs_on_next && (32'(chip_next) == gi));
  end

  always_ff @(posedge tx_clk_90 or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg        <= ST_IDLE;
      cnt_reg          <= 16'd0;
      cycles_reg       <= 16'd0;
      chip_reg         <= '0;
      rwr_reg          <= 4'd0;
      cs_reg           <= '1;
      ck_ena_reg       <= 1'b0;
      sample_reg       <= 1'b0;
      sample_valid_reg <= 1'b0;
      done_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      cycles_reg       <= cycles_next;
      chip_reg         <= chip_next;
      rwr_reg          <= rwr_next;
      cs_reg           <= cs_next;
      ck_ena_reg       <= ck_ena_next;
      sample_reg       <= sample_next;
      sample_valid_reg <= sample_fire;
      done_reg         <= done_next;
    end
  end

  assign hyper_cs_no         = cs_reg;
  assign ck_ena_o            = ck_ena_reg;
  assign rwds_sample_o       = sample_reg;
  assign rwds_sample_valid_o = sample_valid_reg;
  assign done_o              = done_reg;
  assign req_ready_o         = (state_reg == ST_IDLE);
  assign busy_o              = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_hyperbus_cs_sequencer.sv
// Directed bench for hyperbus_cs_sequencer with default parameters.
// Outputs are captured per cycle on the falling edge and checked per scenario.
module tb_hyperbus_cs_sequencer;

  logic        clk;
  logic        rst_ni;
  logic        req_valid;
  logic        req_ready;
  logic [0:0]  req_chip;
  logic [15:0] req_ck;
  logic [3:0]  req_rwr;
  logic        abort;
  logic        rwds;
  logic [1:0]  cs_n;
  logic        ck_ena;
  logic        smp;
  logic        smp_vld;
  logic        done;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [1:0] cs_tr    [0:31];
  logic       ck_tr    [0:31];
  logic       dv_tr    [0:31];
  logic       smp_tr   [0:31];
  logic       done_tr  [0:31];
  logic       ready_tr [0:31];

  hyperbus_cs_sequencer dut (
    .tx_clk_90          (clk),
    .rst_ni             (rst_ni),
    .req_valid_i        (req_valid),
    .req_ready_o        (req_ready),
    .req_chip_i         (req_chip),
    .req_ck_cycles_i    (req_ck),
    .req_rwr_cycles_i   (req_rwr),
    .abort_i            (abort),
    .hyper_rwds_i       (rwds),
    .hyper_cs_no        (cs_n),
    .ck_ena_o           (ck_ena),
    .rwds_sample_o      (smp),
    .rwds_sample_valid_o(smp_vld),
    .done_o             (done),
    .busy_o             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic record(input int k);
    cs_tr[k]    = cs_n;
    ck_tr[k]    = ck_ena;
    dv_tr[k]    = smp_vld;
    smp_tr[k]   = smp;
    done_tr[k]  = done;
    ready_tr[k] = req_ready;
  endtask

  function automatic int count_cs(input logic [1:0] v, input int n);
    int c = 0;
    for (int k = 1; k <= n; k++) if (cs_tr[k] === v) c++;
    return c;
  endfunction

  function automatic int count_ck(input int n);
    int c = 0;
    for (int k = 1; k <= n; k++) if (ck_tr[k] === 1'b1) c++;
    return c;
  endfunction

  function automatic int count_dv(input int n);
    int c = 0;
    for (int k = 1; k <= n; k++) if (dv_tr[k] === 1'b1) c++;
    return c;
  endfunction

  function automatic int count_done(input int n);
    int c = 0;
    for (int k = 1; k <= n; k++) if (done_tr[k] === 1'b1) c++;
    return c;
  endfunction

  // Issues one descriptor; trace index k is cycle t+k after the accepting edge t.
  task automatic run_txn(input logic [0:0] chip, input logic [15:0] n, input logic [3:0] rwr,
                         input int ncyc, input int abort_at);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready got %b want 1", req_ready);
    end
    req_valid = 1'b1;
    req_chip  = chip;
    req_ck    = n;
    req_rwr   = rwr;
    $display("txn chip=%0d n=%0d rwr=%0d abort_at=%0d", chip, n, rwr, abort_at);
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      record(k);
      abort = (k == abort_at);
    end
    abort = 1'b0;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    #12;
    checks++;
    if (cs_n !== 2'b11 || ck_ena !== 1'b0 || smp !== 1'b0 || smp_vld !== 1'b0 ||
        done !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_vals got cs=%b ck=%b s=%b sv=%b d=%b b=%b r=%b want 11 0 0 0 0 0 1",
               cs_n, ck_ena, smp, smp_vld, done, busy, req_ready);
    end
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    checks++;
    if (cs_n !== 2'b11 || ck_ena !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_reset got cs=%b ck=%b b=%b r=%b want 11 0 0 1",
               cs_n, ck_ena, busy, req_ready);
    end
  endtask

  task automatic test_basic;
    rwds = 1'b1;
    run_txn(1'b1, 16'd6, 4'd2, 12, 0);
    checks++;
    if (count_cs(2'b01, 12) != 8) begin
      errors++; $display("FAIL basic_cs_len got %0d want 8", count_cs(2'b01, 12));
    end
    checks++;
    if (cs_tr[1] !== 2'b01 || cs_tr[8] !== 2'b01 || cs_tr[9] !== 2'b11) begin
      errors++; $display("FAIL basic_cs_edges got %b/%b/%b want 01/01/11", cs_tr[1], cs_tr[8], cs_tr[9]);
    end
    checks++;
    if (count_ck(12) != 6 || ck_tr[1] !== 1'b0 || ck_tr[2] !== 1'b1 || ck_tr[7] !== 1'b1) begin
      errors++; $display("FAIL basic_ck got cnt=%0d k1=%b k2=%b k7=%b want 6 0 1 1",
                         count_ck(12), ck_tr[1], ck_tr[2], ck_tr[7]);
    end
    checks++;
    if (dv_tr[5] !== 1'b1 || count_dv(12) != 1 || smp_tr[5] !== 1'b1) begin
      errors++; $display("FAIL basic_sample got dv5=%b cnt=%0d s=%b want 1 1 1",
                         dv_tr[5], count_dv(12), smp_tr[5]);
    end
    checks++;
    if (done_tr[9] !== 1'b1 || count_done(12) != 1) begin
      errors++; $display("FAIL basic_done got d9=%b cnt=%0d want 1 1", done_tr[9], count_done(12));
    end
    checks++;
    if (ready_tr[10] !== 1'b0 || ready_tr[11] !== 1'b1) begin
      errors++; $display("FAIL basic_ready got r10=%b r11=%b want 0 1", ready_tr[10], ready_tr[11]);
    end
  endtask

  task automatic test_zero_cycles;
    run_txn(1'b0, 16'd0, 4'd1, 6, 0);
    checks++;
    if (count_cs(2'b10, 6) != 2 || cs_tr[3] !== 2'b11) begin
      errors++; $display("FAIL zero_cs got cnt=%0d k3=%b want 2 11", count_cs(2'b10, 6), cs_tr[3]);
    end
    checks++;
    if (count_ck(6) != 0 || count_dv(6) != 0) begin
      errors++; $display("FAIL zero_ck_dv got ck=%0d dv=%0d want 0 0", count_ck(6), count_dv(6));
    end
    checks++;
    if (count_done(6) != 1 || done_tr[3] !== 1'b1) begin
      errors++; $display("FAIL zero_done got cnt=%0d k3=%b want 1 1", count_done(6), done_tr[3]);
    end
  endtask

  task automatic test_short_no_sample;
    rwds = 1'b0;
    run_txn(1'b1, 16'd2, 4'd1, 7, 0);
    checks++;
    if (count_dv(7) != 0 || smp_tr[7] !== 1'b1) begin
      errors++; $display("FAIL short_sample got dv=%0d s=%b want 0 1", count_dv(7), smp_tr[7]);
    end
    checks++;
    if (count_ck(7) != 2 || ready_tr[6] !== 1'b1) begin
      errors++; $display("FAIL short_timing got ck=%0d r6=%b want 2 1", count_ck(7), ready_tr[6]);
    end
  endtask

  task automatic test_abort;
    rwds = 1'b0;
    run_txn(1'b1, 16'd10, 4'd3, 9, 4);
    checks++;
    if (ck_tr[4] !== 1'b1 || ck_tr[5] !== 1'b0 || count_ck(9) != 3) begin
      errors++; $display("FAIL abort_ck got k4=%b k5=%b cnt=%0d want 1 0 3", ck_tr[4], ck_tr[5], count_ck(9));
    end
    checks++;
    if (cs_tr[4] !== 2'b01 || cs_tr[5] !== 2'b11) begin
      errors++; $display("FAIL abort_cs got k4=%b k5=%b want 01 11", cs_tr[4], cs_tr[5]);
    end
    checks++;
    if (done_tr[5] !== 1'b1 || count_done(9) != 1) begin
      errors++; $display("FAIL abort_done got k5=%b cnt=%0d want 1 1", done_tr[5], count_done(9));
    end
    checks++;
    if (count_dv(9) != 0 || smp_tr[9] !== 1'b1) begin
      errors++; $display("FAIL abort_sample got dv=%0d s=%b want 0 1", count_dv(9), smp_tr[9]);
    end
    checks++;
    if (ready_tr[7] !== 1'b0 || ready_tr[8] !== 1'b1) begin
      errors++; $display("FAIL abort_ready got r7=%b r8=%b want 0 1", ready_tr[7], ready_tr[8]);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_ready0 got %b want 1", req_ready);
    end
    req_valid = 1'b1;
    req_chip  = 1'b0;
    req_ck    = 16'd2;
    req_rwr   = 4'd0;
    $display("txn chip=0 n=2 rwr=0 then chip=1 n=1 rwr=0 (valid held)");
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      record(k);
      if (k == 2) begin
        req_chip = 1'b1;
        req_ck   = 16'd1;
        req_rwr  = 4'd0;
      end
      if (k == 7) req_valid = 1'b0;
    end
    checks++;
    if (cs_tr[3] !== 2'b10 || cs_tr[4] !== 2'b10 || count_ck(6) != 2) begin
      errors++; $display("FAIL b2b_first got k3=%b k4=%b ck=%0d want 10 10 2", cs_tr[3], cs_tr[4], count_ck(6));
    end
    checks++;
    if (ready_tr[5] !== 1'b0 || ready_tr[6] !== 1'b1 || ready_tr[7] !== 1'b0) begin
      errors++; $display("FAIL b2b_ready got r5=%b r6=%b r7=%b want 0 1 0", ready_tr[5], ready_tr[6], ready_tr[7]);
    end
    checks++;
    if (cs_tr[5] !== 2'b11 || cs_tr[6] !== 2'b11 || cs_tr[7] !== 2'b01) begin
      errors++; $display("FAIL b2b_gap got k5=%b k6=%b k7=%b want 11 11 01", cs_tr[5], cs_tr[6], cs_tr[7]);
    end
    checks++;
    if (ck_tr[8] !== 1'b1 || ck_tr[9] !== 1'b0 || done_tr[5] !== 1'b1 || done_tr[10] !== 1'b1 ||
        count_done(12) != 2) begin
      errors++; $display("FAIL b2b_second got ck8=%b ck9=%b d5=%b d10=%b cnt=%0d want 1 0 1 1 2",
                         ck_tr[8], ck_tr[9], done_tr[5], done_tr[10], count_done(12));
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    req_valid = 1'b1;
    req_chip  = 1'b1;
    req_ck    = 16'd10;
    req_rwr   = 4'd1;
    $display("txn chip=1 n=10 rwr=1 reset during ACTIVE");
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ck_ena !== 1'b1 || cs_n !== 2'b01) begin
      errors++; $display("FAIL rst_pre got ck=%b cs=%b want 1 01", ck_ena, cs_n);
    end
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if (cs_n !== 2'b11 || ck_ena !== 1'b0 || done !== 1'b0 || smp !== 1'b0 ||
        busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_async got cs=%b ck=%b d=%b s=%b b=%b r=%b want 11 0 0 0 0 1",
                         cs_n, ck_ena, done, smp, busy, req_ready);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || cs_n !== 2'b11) begin
        errors++; $display("FAIL rst_hold got d=%b cs=%b want 0 11", done, cs_n);
      end
    end
    rst_ni = 1'b1;
    run_txn(1'b0, 16'd1, 4'd1, 5, 0);
    checks++;
    if (cs_tr[1] !== 2'b10 || ck_tr[2] !== 1'b1 || done_tr[4] !== 1'b1 || ready_tr[5] !== 1'b1) begin
      errors++; $display("FAIL rst_after got cs1=%b ck2=%b d4=%b r5=%b want 10 1 1 1",
                         cs_tr[1], ck_tr[2], done_tr[4], ready_tr[5]);
    end
  endtask

  initial begin
    req_valid = 1'b0;
    req_chip  = 1'b0;
    req_ck    = 16'd0;
    req_rwr   = 4'd0;
    abort     = 1'b0;
    rwds      = 1'b0;
    test_reset();
    test_basic();
    test_zero_cycles();
    test_short_no_sample();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
